// File: rtl/rs_dec_syndrome_calc_param.sv
// Parametrised GF(2^8) Reed-Solomon syndrome calculator (serves CIRC C1 and C2).
// Horner-accumulates P_NSYM syndromes per P_N-symbol codeword, one symbol per strobe toggle.
module rs_dec_syndrome_calc_param #(
  parameter int          P_N         = 32,
  parameter int          P_NSYM      = 4,
  parameter int          P_FCR       = 0,
  parameter logic [8:0]  P_POLY      = 9'h11D,
  parameter bit          P_NEED_SYNC = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_res,
  input  logic                  i_frame_sync,
  input  logic [7:0]            i_data,
  input  logic                  i_data_sync,
  output logic [8*P_NSYM-1:0]   o_syn,
  output logic                  o_valid,
  output logic                  o_err,
  output logic                  o_abort,
  output logic [7:0]            o_cnt
);

  if (P_N < 2 || P_N > 255 || P_NSYM < 1 || P_NSYM > 16 || P_FCR < 0) begin : g_bad_param
    $error("rs_dec_syndrome_calc_param: parameter out of range");
  end

  typedef enum logic {S_WAIT, S_ACC} state_t;

  // Multiplier collapses to fixed XOR trees because b is always an elaboration constant.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? P_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input int unsigned e);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned k = 0; k < e; k++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  state_t                   state, state_nxt;
  logic [1:0]               r_sync;
  logic                     stb;
  logic [P_NSYM-1:0][7:0]   acc, acc_nxt, syn_q;
  logic [7:0]               cnt;
  logic                     sym_take, word_end;

  assign stb   = r_sync[0] ^ r_sync[1];
  assign o_syn = syn_q;
  assign o_cnt = cnt;

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) state <= P_NEED_SYNC ? S_WAIT : S_ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_WAIT && i_frame_sync) state_nxt = S_ACC;
  end

  always_comb begin
    sym_take = stb && (state == S_ACC);
    word_end = sym_take && !i_frame_sync && (cnt == 8'(P_N - 1));
  end

  always_comb begin
    acc_nxt = '0;
    for (int unsigned i = 0; i < P_NSYM; i++)
      acc_nxt[i] = gf_mul(acc[i], gf_pow(P_FCR + i)) ^ i_data;
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_sync  <= '0;
      acc     <= '0;
      syn_q   <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_abort <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_data_sync};
      o_valid <= 1'b0;
      o_abort <= 1'b0;
      // Frame sync overrides a word end; a coincident symbol restarts the word as symbol 0.
      if (i_frame_sync) begin
        o_abort <= (cnt != '0);
        if (stb) begin
          acc <= {P_NSYM{i_data}};
          cnt <= 8'd1;
        end else begin
          acc <= '0;
          cnt <= '0;
        end
      end else if (word_end) begin
        syn_q   <= acc_nxt;
        o_err   <= |acc_nxt;
        o_valid <= 1'b1;
        acc     <= '0;
        cnt     <= '0;
      end else if (sym_take) begin
        acc <= acc_nxt;
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rs_dec_syndrome_calc_param.sv
// Directed bench for rs_dec_syndrome_calc_param: default RS(32,28) instance plus
// a P_N=28 / P_FCR=1 instance, with hand-computed syndromes.
module tb_rs_dec_syndrome_calc_param;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        fs = 1'b0, ds = 1'b0;
  logic [7:0]  d = '0;
  logic [31:0] syn;
  logic        valid, err, abort;
  logic [7:0]  cnt;

  logic        fs2 = 1'b0, ds2 = 1'b0;
  logic [7:0]  d2 = '0;
  logic [31:0] syn2;
  logic        valid2, err2, abort2;
  logic [7:0]  cnt2;

  int ntests = 0;
  int nfail  = 0;
  int nvalid = 0;
  int nabort = 0;

  always #5 clk = ~clk;

  rs_dec_syndrome_calc_param dut (
    .i_clk(clk), .i_res(res), .i_frame_sync(fs), .i_data(d), .i_data_sync(ds),
    .o_syn(syn), .o_valid(valid), .o_err(err), .o_abort(abort), .o_cnt(cnt)
  );

  rs_dec_syndrome_calc_param #(.P_N(28), .P_NSYM(4), .P_FCR(1), .P_POLY(9'h11D), .P_NEED_SYNC(1'b1)) dut2 (
    .i_clk(clk), .i_res(res), .i_frame_sync(fs2), .i_data(d2), .i_data_sync(ds2),
    .o_syn(syn2), .o_valid(valid2), .o_err(err2), .o_abort(abort2), .o_cnt(cnt2)
  );

  always @(negedge clk) begin
    if (valid) nvalid++;
    if (abort) nabort++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    @(posedge clk); #1;
    d  = v;
    ds = ~ds;
    repeat (3) @(posedge clk);
  endtask

  task automatic send2(input logic [7:0] v);
    @(posedge clk); #1;
    d2  = v;
    ds2 = ~ds2;
    repeat (3) @(posedge clk);
  endtask

  task automatic frame_sync();
    @(posedge clk); #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_syn", 64'(syn), 64'h0);
    chk("reset_err", 64'(err), 64'h0);
    chk("reset_valid", 64'(valid), 64'h0);
    chk("reset_cnt", 64'(cnt), 64'h0);
    res = 1'b0;
    repeat (4) @(posedge clk);

    // WAIT state: strobes without a frame sync are ignored
    for (int k = 0; k < 32; k++) send(8'h00);
    chk("wait_no_valid", 64'(nvalid), 64'd0);
    chk("wait_cnt", 64'(cnt), 64'd0);

    frame_sync();
    for (int k = 0; k < 32; k++) send(8'h00);
    chk("zero_valid_cnt", 64'(nvalid), 64'd1);
    chk("zero_syn", 64'(syn), 64'h0);
    chk("zero_err", 64'(err), 64'h0);
    chk("zero_cnt_wrap", 64'(cnt), 64'd0);

    frame_sync();
    for (int k = 0; k < 31; k++) send(8'h00);
    send(8'h01);
    chk("last1_valid_cnt", 64'(nvalid), 64'd2);
    chk("last1_syn", 64'(syn), 64'h01010101);
    chk("last1_err", 64'(err), 64'h1);

    frame_sync();
    for (int k = 0; k < 30; k++) send(8'h00);
    send(8'h01);
    send(8'h00);
    chk("pos30_syn", 64'(syn), 64'h08040201);
    chk("pos30_valid_cnt", 64'(nvalid), 64'd3);

    // Partial word truncated by a frame sync
    frame_sync();
    for (int k = 0; k < 10; k++) send(8'h55);
    chk("partial_cnt", 64'(cnt), 64'd10);
    frame_sync();
    chk("abort_cnt", 64'(nabort), 64'd1);
    chk("abort_no_valid", 64'(nvalid), 64'd3);
    chk("abort_syn_held", 64'(syn), 64'h08040201);
    chk("abort_cnt_zero", 64'(cnt), 64'd0);
    for (int k = 0; k < 29; k++) send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    chk("after_abort_valid_cnt", 64'(nvalid), 64'd4);
    chk("after_abort_syn", 64'(syn), 64'h40100401);

    // Frame sync coincident with the 32nd symbol's strobe: frame sync wins
    frame_sync();
    for (int k = 0; k < 31; k++) send(8'h00);
    @(posedge clk); #1;
    d  = 8'h00;
    ds = ~ds;
    @(posedge clk); #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
    chk("coinc_abort", 64'(abort), 64'h1);
    chk("coinc_no_valid", 64'(valid), 64'h0);
    chk("coinc_cnt", 64'(cnt), 64'd1);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 30; k++) send(8'h00);
    send(8'h01);
    chk("coinc_word_syn", 64'(syn), 64'h01010101);
    chk("coinc_valid_cnt", 64'(nvalid), 64'd5);
    chk("coinc_abort_cnt", 64'(nabort), 64'd2);

    // Asynchronous reset mid-word
    frame_sync();
    for (int k = 0; k < 15; k++) send(8'h33);
    #3 res = 1'b1;
    #1;
    chk("async_rst_syn", 64'(syn), 64'h0);
    chk("async_rst_err", 64'(err), 64'h0);
    chk("async_rst_cnt", 64'(cnt), 64'h0);
    chk("async_rst_valid", 64'(valid), 64'h0);
    chk("async_rst_abort", 64'(abort), 64'h0);
    @(posedge clk); #1 res = 1'b0;
    repeat (4) @(posedge clk);
    for (int k = 0; k < 4; k++) send(8'h77);
    chk("post_rst_wait_cnt", 64'(cnt), 64'd0);
    frame_sync();
    for (int k = 0; k < 30; k++) send(8'h00);
    send(8'h01);
    send(8'h00);
    chk("post_rst_syn", 64'(syn), 64'h08040201);
    chk("post_rst_valid_cnt", 64'(nvalid), 64'd6);

    // RS(28,24) with first root alpha^1, valid latency one cycle after last strobe
    @(posedge clk); #1 fs2 = 1'b1;
    @(posedge clk); #1 fs2 = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 26; k++) send2(8'h00);
    send2(8'h01);
    chk("c2_cnt_before_last", 64'(cnt2), 64'd27);
    @(posedge clk); #1;
    d2  = 8'h00;
    ds2 = ~ds2;
    @(posedge clk); #1;
    chk("c2_valid_stb_cycle", 64'(valid2), 64'h0);
    @(posedge clk); #1;
    chk("c2_valid_pulse", 64'(valid2), 64'h1);
    chk("c2_syn", 64'(syn2), 64'h10080402);
    chk("c2_err", 64'(err2), 64'h1);
    @(posedge clk); #1;
    chk("c2_valid_one_cycle", 64'(valid2), 64'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/rs_dec_syndrome_calc_param.md
Name: rs_dec_syndrome_calc_param

Overview:
Parametrised GF(2^8) Reed-Solomon syndrome calculator. It is the generalised successor of the fixed RS(32,28) syndrome unit and serves both CIRC decoder stages (C1 = RS(32,28), C2 = RS(28,24)) from one RTL source. It accepts one symbol per toggle of a cross-domain data strobe, Horner-accumulates P_NSYM syndromes over a P_N-symbol codeword, and presents a held result with a valid pulse, a nonzero flag and codeword-alignment handling.

Parameters:
P_N, 32, codeword length in symbols; legal range 2..255.
P_NSYM, 4, number of syndromes (parity symbols); legal range 1..16.
P_FCR, 0, exponent of the first consecutive root; syndrome i uses root alpha^(P_FCR+i).
P_POLY, 9'h11D, GF(2^8) primitive polynomial; alpha = 8'h02.
P_NEED_SYNC, 1, when 1 symbols are ignored after reset until the first i_frame_sync.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_res  in  1  reset; asynchronous and active-high.
i_frame_sync  in  1  synchronous to i_clk, single-cycle; the next symbol (or a coincident symbol) is symbol 0.
i_data  in  8  symbol value; stable from its strobe toggle until 3 i_clk cycles later.
i_data_sync  in  1  toggle strobe from the deframer domain; each edge (either direction) marks one new symbol.
o_syn  out  8*P_NSYM  held syndromes; S_i occupies bits [8i+7:8i].
o_valid  out  1  one-cycle pulse when o_syn has been updated.
o_err  out  1  held; 1 when any S_i of the last codeword is nonzero.
o_abort  out  1  one-cycle pulse when a frame sync truncates a partial codeword.
o_cnt  out  8  current symbol index within the codeword; 0..P_N-1.

Behaviour:
- Reset (async, i_res=1): sync flops, accumulators, counter, o_syn, o_err, o_valid, o_abort and o_cnt all go to 0. State becomes WAIT when P_NEED_SYNC=1, otherwise ACC.
- Strobe detection: 2-flop synchroniser r_sync[1:0] on i_data_sync; stb = r_sync[0]^r_sync[1].
  - stb is high for exactly 1 cycle per input edge, 2 cycles after the edge.
  - i_data is sampled in the stb cycle.
  - Toggles closer than 2 cycles apart are outside the contract.
- Accumulation on stb in ACC: acc_i <= gfmul(acc_i, alpha^(P_FCR+i)) ^ i_data, for every i.
  - gfmul by a constant is elaboration-time XOR logic.
  - Syndrome i equals sum over j of d_j * alpha^((P_FCR+i)*(P_N-1-j)).
- Counter: cnt increments on each accepted stb.
  - On a stb with cnt==P_N-1, in the same edge: o_syn <= next acc values (including the current symbol), o_err <= OR of those values, acc <= 0, cnt <= 0.
  - o_valid is 1 for the cycle following that edge, so latency from stb of the last symbol to o_valid is 1 cycle.
- Output holding: o_syn and o_err are held until the next completed codeword. Partial words never alter them.
- States:
  - WAIT: stb ignored, cnt stays 0. i_frame_sync -> ACC.
  - ACC: normal operation.
  - There is no terminal state; the block runs continuously.
- i_frame_sync in ACC:
  - acc <= 0, cnt <= 0.
  - If cnt!=0, o_abort pulses next cycle and o_syn is unchanged.
- i_frame_sync coincident with stb (either state): the word restarts, and the current symbol becomes symbol 0, so acc_i <= i_data and cnt <= 1. o_abort follows the rule above, judged on the old cnt.
- i_frame_sync coincident with a stb at cnt==P_N-1: the frame sync wins. The word is aborted with o_abort, there is no o_valid, and the symbol is taken as symbol 0.
- P_N==1 is illegal; a simulation-only assertion flags out-of-range parameters.
- A mid-word reset discards the partial word. After release, the block behaves as after power-up, including WAIT.

Test Plan:
- Default parameters, frame sync then 32 symbols of 8'h00 -> exactly one o_valid pulse; o_syn all 8'h00; o_err=0.
- Frame sync, 31 symbols of 00 then one 8'h01 -> o_syn = {01,01,01,01}, o_err=1. Then frame sync, 30 zeros, 01, 00 -> S0..S3 = 01,02,04,08.
- P_N=28, P_FCR=1, symbols 00 x26, 01, 00 -> S0..S3 = 02,04,08,10; o_valid 1 cycle after the 28th stb.
- Frame sync, 10 symbols, frame sync -> o_abort pulse, no o_valid, o_syn unchanged. The next 32 symbols produce a correct valid result.
- Toggle i_data_sync 32 times with no frame sync after reset (P_NEED_SYNC=1) -> no o_valid; o_cnt stays 0.
- Assert i_res at symbol 15 -> all outputs 0 asynchronously. After release, a full frame sync + codeword yields correct syndromes.
